// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32 funct3 size codes
// and the funct3 legality check.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_legal_funct3(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: load extraction with sign/zero extension, and merging of sub-word
// store data into the old memory word. Little-endian lanes.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_offset,
    input  logic [WORD_W-1:0] i_word,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data_c,
    output logic [WORD_W-1:0] o_store_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    // Load path: lane select then extend
    always_comb begin
        o_load_data_c = i_word;
        case (i_funct3)
            F3_B:    o_load_data_c = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data_c = {24'h0, w_byte};
            F3_H:    o_load_data_c = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data_c = {16'h0, w_half};
            default: o_load_data_c = i_word;
        endcase
    end

    // Store path: replace target lane(s) of the old word
    always_comb begin
        o_store_data_c = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_store_data_c = i_word;
                o_store_data_c[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_H: begin
                o_store_data_c = i_word;
                if (i_offset[1]) begin
                    o_store_data_c[31:16] = i_wdata[15:0];
                end else begin
                    o_store_data_c[15:0] = i_wdata[15:0];
                end
            end
            default: o_store_data_c = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time, checks it, performs the memory
// read / write (read-modify-write for sub-word stores) and returns one response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_DEPTH     = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    lsu_state_e r_state;
    lsu_state_e w_next_state;

    logic                     r_we;
    logic [2:0]               r_funct3;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_resp_rdata;
    logic                     r_resp_err;
    logic [DATA_WIDTH-1:0]    r_mem_wd;

    logic [ADDRESS_WIDTH-1:0] w_req_idx;
    logic                     w_req_err;
    logic                     w_req_store_word;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic [DATA_WIDTH-1:0]    w_store_data;

    assign w_req_idx        = req_addr >> 2;
    assign w_req_store_word = req_we && (req_funct3 == F3_W);

    // Request is rejected without touching memory
    assign w_req_err = !is_legal_funct3(req_funct3)
                    || (req_we && req_funct3[2])
                    || ((req_funct3[1:0] == 2'b01) && req_addr[0])
                    || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00))
                    || (w_req_idx >= ADDRESS_WIDTH'(MEM_DEPTH));

    lsu_align u_align (
        .i_funct3       (r_funct3),
        .i_offset       (r_addr[1:0]),
        .i_word         (mem_rd),
        .i_wdata        (r_wdata),
        .o_load_data_c  (w_load_data),
        .o_store_data_c (w_store_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_next_state = RESP;
                    end else if (w_req_store_word) begin
                        w_next_state = WRITE;
                    end else begin
                        w_next_state = READ;
                    end
                end
            end
            READ:    w_next_state = r_we ? WRITE : RESP;
            WRITE:   w_next_state = RESP;
            RESP:    w_next_state = resp_ready ? IDLE : RESP;
            default: w_next_state = IDLE;
        endcase
    end

    // Request latch and response / write-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_mem_wd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we         <= req_we;
                        r_funct3     <= req_funct3;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_resp_err   <= w_req_err;
                        r_resp_rdata <= '0;
                        if (w_req_store_word && !w_req_err) begin
                            r_mem_wd <= req_wdata;
                        end
                    end
                end
                READ: begin
                    if (r_we) begin
                        r_mem_wd <= w_store_data;
                    end else begin
                        r_resp_rdata <= w_load_data;
                        r_resp_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign mem_wr_en  = (r_state == WRITE);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_addr >> 2;
    assign mem_wd     = r_mem_wd;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized requests checked against an
// arithmetic reference model of memory and the request rules.
module tb_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int checks;
    int errors;

    logic        obs_err;
    logic [31:0] obs_rdata;
    logic [31:0] obs_wr_idx;
    logic [31:0] obs_wr_data;
    int          obs_lat;
    int          obs_wr_cnt;
    logic        obs_stable;

    lsu_ctrl #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge; pre_we is a bench preload port
    assign mem_rd = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_wr_en && (mem_addr < 32'd256)) begin
            mem[mem_addr[7:0]] <= mem_wd;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = idx[7:0];
        pre_data = data;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request and observe latency, write pulses and response; stall = resp_ready low cycles
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall);
        int n;
        obs_lat = 0; obs_wr_cnt = 0; obs_stable = 1'b1;
        obs_wr_idx = 32'h0; obs_wr_data = 32'h0; obs_rdata = 32'h0; obs_err = 1'b0;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: req_ready=%b required 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        do begin
            @(negedge clk);
            obs_lat++;
            if (mem_wr_en === 1'b1) begin
                obs_wr_cnt++;
                obs_wr_idx  = mem_addr;
                obs_wr_data = mem_wd;
            end
        end while (resp_valid !== 1'b1 && obs_lat < 20);
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_valid_timeout: resp_valid=%b required 1", resp_valid);
            return;
        end
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== obs_rdata || resp_err !== obs_err ||
                req_ready !== 1'b0 || mem_wr_en !== 1'b0) obs_stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    // Reference model: expected outcome of a request computed from the access rules
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic e_err,
                              output logic [31:0] e_rdata, output int e_lat, output int e_wr,
                              output logic [31:0] e_idx, output logic [31:0] e_data);
        longint unsigned idx, off, size, mask, word, v;
        idx  = addr / 4;
        off  = addr % 4;
        size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        e_err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (we && f3 >= 4) ||
                (addr % size != 0) || (idx >= 256);
        e_rdata = 32'h0; e_wr = 0; e_idx = 32'h0; e_data = 32'h0;
        mask = (64'd1 << (8 * size)) - 1;
        if (e_err) begin
            e_lat = 1;
        end else if (!we) begin
            word = ref_mem[idx[7:0]];
            v = (word >> (8 * off)) & mask;
            if (f3 < 4 && size < 4 && v >= (mask + 1) / 2) v = v | ~mask;
            e_rdata = v[31:0];
            e_lat = 2;
        end else begin
            word = ref_mem[idx[7:0]];
            word = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
            ref_mem[idx[7:0]] = word[31:0];
            e_wr = 1; e_idx = idx[31:0]; e_data = word[31:0];
            e_lat = (size == 4) ? 2 : 3;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
            mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b rdata=%h err=%b we=%b addr=%h wd=%h required 1 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, mem_wr_en, mem_addr, mem_wd);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_store_word;
        preload(4, 32'h0);
        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0);
        checks++;
        if (obs_wr_cnt !== 1 || obs_wr_idx !== 32'd4 || obs_wr_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_write: pulses=%0d idx=%0d data=%h required 1 4 deadbeef",
                     obs_wr_cnt, obs_wr_idx, obs_wr_data);
        end
        checks++;
        if (obs_lat !== 2 || obs_err !== 1'b0 || obs_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sw_resp: lat=%0d err=%b rdata=%h required 2 0 0", obs_lat, obs_err, obs_rdata);
        end
        @(negedge clk);
        checks++;
        if (mem[4] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL sw_mem: mem[4]=%h required deadbeef", mem[4]);
        end
    endtask

    task automatic test_load_extend;
        logic [2:0]  f3s  [0:3] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [0:3] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exps [0:3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
        preload(4, 32'h80FF_7F01);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], adrs[i], 32'h0, 0);
            checks++;
            if (obs_rdata !== exps[i] || obs_err !== 1'b0 || obs_lat !== 2 || obs_wr_cnt !== 0) begin
                errors++;
                $display("FAIL load_ext[%0d]: rdata=%h err=%b lat=%0d wr=%0d required %h 0 2 0",
                         i, obs_rdata, obs_err, obs_lat, obs_wr_cnt, exps[i]);
            end
        end
    endtask

    task automatic test_subword_store;
        preload(4, 32'h1122_3344);
        issue(1'b1, 3'b000, 32'h11, 32'h5555_55AA, 0);
        checks++;
        if (obs_lat !== 3 || obs_err !== 1'b0 || obs_wr_cnt !== 1 || obs_wr_data !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL sb: lat=%0d err=%b wr=%0d wd=%h required 3 0 1 1122aa44",
                     obs_lat, obs_err, obs_wr_cnt, obs_wr_data);
        end
        checks++;
        if (mem[4] !== 32'h1122_AA44) begin
            errors++;
            $display("FAIL sb_mem: mem[4]=%h required 1122aa44", mem[4]);
        end
        issue(1'b1, 3'b001, 32'h12, 32'h1234_BBCC, 0);
        checks++;
        if (obs_lat !== 3 || obs_wr_cnt !== 1 || mem[4] !== 32'hBBCC_AA44) begin
            errors++;
            $display("FAIL sh: lat=%0d wr=%0d mem[4]=%h required 3 1 bbccaa44", obs_lat, obs_wr_cnt, mem[4]);
        end
    endtask

    task automatic test_errors;
        logic        wes  [0:3] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s  [0:3] = '{3'b010, 3'b001, 3'b010, 3'b011};
        logic [31:0] adrs [0:3] = '{32'h02, 32'h03, 32'h400, 32'h08};
        preload(0, 32'hA5A5_0F0F);
        preload(2, 32'h3C3C_C3C3);
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 0);
            checks++;
            if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 1 || obs_wr_cnt !== 0) begin
                errors++;
                $display("FAIL err_req[%0d]: err=%b rdata=%h lat=%0d wr=%0d required 1 0 1 0",
                         i, obs_err, obs_rdata, obs_lat, obs_wr_cnt);
            end
        end
        checks++;
        if (mem[0] !== 32'hA5A5_0F0F || mem[2] !== 32'h3C3C_C3C3) begin
            errors++;
            $display("FAIL err_mem: mem[0]=%h mem[2]=%h required a5a50f0f 3c3cc3c3", mem[0], mem[2]);
        end
    endtask

    task automatic test_back_pressure;
        int          n;
        logic [31:0] r0;
        logic        ok;
        preload(5, 32'h0BAD_CAFE);
        preload(6, 32'h1357_9BDF);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_funct3 = 3'b101; req_addr = 32'h1A;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid !== 1'b1 && n < 20);
        checks++;
        if (n !== 2 || resp_rdata !== 32'h0BAD_CAFE || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_first: lat=%0d rdata=%h err=%b required 2 0badcafe 0", n, resp_rdata, resp_err);
        end
        r0 = resp_rdata;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== r0 || req_ready !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_hold: stable=%b required 1", ok);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: req_ready=%b resp_valid=%b required 1 0", req_ready, resp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept: req_ready=%b required 0", req_ready);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (resp_valid !== 1'b1 && n < 20);
        checks++;
        if (n !== 2 || resp_rdata !== 32'h0000_1357 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_second: lat=%0d rdata=%h err=%b required 2 00001357 0", n, resp_rdata, resp_err);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset_in_write;
        preload(8, 32'hCAFE_F00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rw_in_write: mem_wr_en=%b required 1", mem_wr_en);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_async_drop: mem_wr_en=%b resp_valid=%b required 0 0", mem_wr_en, resp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem[8] !== 32'hCAFE_F00D || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL rw_after: req_ready=%b mem[8]=%h addr=%h wd=%h required 1 cafef00d 0 0",
                     req_ready, mem[8], mem_addr, mem_wd);
        end
    endtask

    task automatic test_random;
        logic [2:0]  f3_tab [0:9] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        logic        we, e_err;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, e_rdata, e_idx, e_data, rnd;
        int          r, e_lat, e_wr, stall;
        for (int i = 0; i < 256; i++) begin
            rnd = $urandom;
            ref_mem[i] = rnd;
            preload(i, rnd);
        end
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = f3_tab[$urandom_range(0, 9)];
            r     = $urandom_range(0, 7);
            addr  = 32'($urandom_range(0, 1023));
            if (r < 4) addr[1:0] = 2'b00;
            if (r == 7) addr = 32'h400 + 32'($urandom_range(0, 4095));
            wdata = $urandom;
            stall = $urandom_range(0, 2);
            ref_access(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_wr, e_idx, e_data);
            issue(we, f3, addr, wdata, stall);
            checks++;
            if (obs_err !== e_err || obs_rdata !== e_rdata || obs_lat !== e_lat) begin
                errors++;
                $display("FAIL rnd_resp[%0d] we=%b f3=%0d addr=%h: err=%b rdata=%h lat=%0d required %b %h %0d",
                         i, we, f3, addr, obs_err, obs_rdata, obs_lat, e_err, e_rdata, e_lat);
            end
            checks++;
            if (obs_wr_cnt !== e_wr || (e_wr == 1 && (obs_wr_idx !== e_idx || obs_wr_data !== e_data))) begin
                errors++;
                $display("FAIL rnd_write[%0d]: pulses=%0d idx=%0d data=%h required %0d %0d %h",
                         i, obs_wr_cnt, obs_wr_idx, obs_wr_data, e_wr, e_idx, e_data);
            end
            checks++;
            if (!obs_stable) begin
                errors++;
                $display("FAIL rnd_hold[%0d]: stable=%b required 1", i, obs_stable);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL rnd_mem[%0d]: %h required %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        resp_ready = 1'b0;
        pre_we = 1'b0; pre_idx = 8'h0; pre_data = 32'h0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_subword_store();
        test_errors();
        test_back_pressure();
        test_reset_in_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
